sram_read_streamer: RTL

//  Read sequencer between single_port_sram and serial consumers (serial_to_parallel_rf, shift_buffer).
//  On start, issues len reads from base_addr upward, at most one every II cycles.

---
 rtl/sram_read_streamer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_read_streamer.sv
// sram_read_streamer
//   Walks a block of SRAM words starting at base_addr (wrapping modulo DEPTH),
//   reading at most one word every II cycles, and hands the words to a serial
//   consumer as a valid/ready stream tagged with last on the final word.
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     start, base_addr,   transfer request; base_addr/len sampled with start
//     len                 in IDLE only
//     busy, done          busy from the cycle after an accepted start until
//                         done; done is a 1-cycle completion pulse
//     mem_addr, mem_ren,  SRAM read port (read data arrives the cycle after
//     mem_q               mem_ren)
//     out_valid,          output stream; a word moves when out_valid and
//     out_ready,          out_ready are both high; out_data/out_last hold
//     out_data, out_last  while out_valid & !out_ready
//
//   Build option: define SRAM_READ_STREAMER_CHECK_EN to enable simulation
//   checks (start while busy, FIFO overflow, len > DEPTH). Without it, start
//   while busy is ignored and len > DEPTH is truncated to DEPTH.
//
//   Handshake: out_valid never depends on out_ready; once raised it stays high
//   with stable data until the word is taken. mem_ren depends only on
//   registered state, so there is no out_ready -> mem_ren path.
module sram_read_streamer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int II         = 1,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_ren,
    input  logic [WIDTH-1:0] mem_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int LW  = AW + 1;
    localparam int IIW = (II > 1) ? $clog2(II) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state;
    logic [AW-1:0]   cur;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   issued;
    logic [IIW-1:0]  ii_cnt;
    logic            inflight;       // a read issued last cycle; its data is on mem_q now
    logic            inflight_last;  // that read is the final word of the transfer
    logic            zero_done;      // len==0 completion pulse

    logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic             last_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [LW-1:0]    len_eff;
    logic [CW-1:0]    occ;
    logic             issue;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_data;
    logic             head_last;
    logic             pop;
    logic             pop_store;
    logic             push_store;
    logic             last_pop;

`ifdef SRAM_READ_STREAMER_CHECK_EN
    assign len_eff = len;
`else
    assign len_eff = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
`endif

    // Credit: words stored plus the word arriving this cycle must leave room.
    assign occ   = count + CW'(inflight);
    assign issue = (state == ISSUE) && (ii_cnt == '0) &&
                   (occ < CW'(FIFO_DEPTH)) && (issued < len_q);

    assign mem_ren  = issue;
    assign mem_addr = issue ? cur : addr_q;
    assign busy     = (state != IDLE);

    // Fall-through FIFO: when empty, the arriving SRAM word is presented
    // directly; if not taken it is stored and shown from the head next cycle.
    assign fifo_empty = (count == '0);
    assign out_valid  = !fifo_empty || inflight;

    always_comb begin
        head_data = '0;
        head_last = 1'b0;
        if (!fifo_empty) begin
            head_data = data_mem[rd_ptr];
            head_last = last_mem[rd_ptr];
        end else if (inflight) begin
            head_data = mem_q;
            head_last = inflight_last;
        end
    end

    assign out_data   = head_data;
    assign out_last   = head_last;
    assign pop        = out_valid && out_ready;
    assign pop_store  = pop && !fifo_empty;
    assign push_store = inflight && !(fifo_empty && pop);
    assign last_pop   = pop && out_last;
    assign done       = ((state == DRAIN) && last_pop) || zero_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur           <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            issued        <= '0;
            ii_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            zero_done     <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (issued == len_q - LW'(1));
            if (ii_cnt != '0) begin
                ii_cnt <= ii_cnt - IIW'(1);
            end
            case (state)
                IDLE: begin
                    // A pending zero-length completion counts as the done cycle.
                    if (start && !zero_done) begin
                        cur    <= base_addr;
                        len_q  <= len_eff;
                        issued <= '0;
                        if (len_eff == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        cur    <= (cur == AW'(DEPTH - 1)) ? '0 : cur + AW'(1);
                        addr_q <= cur;
                        issued <= issued + LW'(1);
                        ii_cnt <= IIW'(II - 1);
                        if (issued + LW'(1) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_store) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_store) - CW'(pop_store);
        end
    end

    // Storage needs no reset: entries are only visible while count says so.
    always_ff @(posedge clk) begin
        if (push_store) begin
            data_mem[wr_ptr] <= mem_q;
            last_mem[wr_ptr] <= inflight_last;
        end
    end

`ifdef SRAM_READ_STREAMER_CHECK_EN
    always @(posedge clk) begin
        if (rst) begin
            if (start && busy && !done) begin
                $display("ERROR: start while busy");
                $finish(1);
            end
            if (inflight && (count == CW'(FIFO_DEPTH)) && !pop) begin
                $display("ERROR: FIFO push when full");
                $finish(1);
            end
            if (start && (state == IDLE) && (len > LW'(DEPTH))) begin
                $display("ERROR: len > DEPTH");
                $finish(1);
            end
        end
    end
`endif

endmodule
